// File: rtl/sw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_pkg: shared constants, base encodings and controller states       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sw_pkg;

  localparam int SCORE_WIDTH = 11;
  localparam int LENGTH      = 48;
  localparam int LOG_LENGTH  = 6;
  localparam int TLEN_W      = 16;
  localparam int ZERO        = 1 << (SCORE_WIDTH - 1);

  localparam logic [1:0] _A = 2'b00;
  localparam logic [1:0] _G = 2'b01;
  localparam logic [1:0] _T = 2'b10;
  localparam logic [1:0] _C = 2'b11;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    LOAD_Q = 6'b000010,
    CLEAR  = 6'b000100,
    STREAM = 6'b001000,
    DRAIN  = 6'b010000,
    RESULT = 6'b100000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sw_score_unbias.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_score_unbias: registered bias removal of the array's best score   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sw_score_unbias #(
  parameter int SCORE_WIDTH = sw_pkg::SCORE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [SCORE_WIDTH-1:0] high,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam logic [SCORE_WIDTH-1:0] BIAS = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  // Scores below the bias point are negative alignments and report as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
    end else if (clear) begin
      score <= '0;
    end else if (load) begin
      score <= (high >= BIAS) ? (high - BIAS) : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sw_array_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_array_controller: job sequencer for the Smith-Waterman PE array   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sw_array_controller #(
  parameter int SCORE_WIDTH   = sw_pkg::SCORE_WIDTH,
  parameter int LENGTH        = sw_pkg::LENGTH,
  parameter int LOG_LENGTH    = sw_pkg::LOG_LENGTH,
  parameter int TLEN_W        = sw_pkg::TLEN_W,
  parameter int DRAIN_TIMEOUT = 2 * LENGTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LOG_LENGTH:0]    cmd_qlen,
  input  logic [TLEN_W-1:0]      cmd_tlen,
  input  logic                   q_valid,
  input  logic [1:0]             q_data,
  output logic                   q_ready,
  input  logic                   t_valid,
  input  logic [1:0]             t_data,
  output logic                   t_ready,
  output logic                   pe_q_shift,
  output logic [1:0]             pe_q_data,
  output logic                   pe_q_mask,
  output logic                   pe_rst_n,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic                   pe_first,
  input  logic                   last_vld,
  input  logic [SCORE_WIDTH-1:0] last_high,
  output logic                   res_valid,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   res_err,
  input  logic                   res_ready
);

  import sw_pkg::*;

  localparam int CNT_W = LOG_LENGTH + 1;
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LENGTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   qlen, qlen_nxt;
  logic [TLEN_W-1:0]  tlen, tlen_nxt;
  logic [TLEN_W-1:0]  tcnt, tcnt_nxt;
  logic [TMO_W-1:0]   tmo, tmo_nxt;

  logic               cmd_ready_nxt, q_ready_nxt, t_ready_nxt;
  logic               pe_q_shift_nxt, pe_q_mask_nxt, pe_rst_n_nxt;
  logic               pe_en_nxt, pe_first_nxt;
  logic [1:0]         pe_q_data_nxt, pe_data_nxt;
  logic               res_valid_nxt, res_err_nxt;
  logic               score_load, score_clear;
  logic               shifted;
  logic [CNT_W-1:0]   npad;

  assign npad = LEN_C - qlen;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    qlen_nxt       = qlen;
    tlen_nxt       = tlen;
    tcnt_nxt       = tcnt;
    tmo_nxt        = tmo;
    cmd_ready_nxt  = 1'b0;
    t_ready_nxt    = 1'b0;
    pe_q_shift_nxt = 1'b0;
    pe_q_data_nxt  = _A;
    pe_q_mask_nxt  = 1'b0;
    pe_rst_n_nxt   = 1'b1;
    pe_en_nxt      = 1'b0;
    pe_data_nxt    = _A;
    pe_first_nxt   = 1'b0;
    res_valid_nxt  = res_valid;
    res_err_nxt    = res_err;
    score_load     = 1'b0;
    score_clear    = 1'b0;
    shifted        = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          if ((cmd_qlen == '0) || (cmd_qlen > LEN_C) || (cmd_tlen == '0)) begin
            state_nxt     = RESULT;
            res_valid_nxt = 1'b1;
            res_err_nxt   = 1'b1;
            score_clear   = 1'b1;
          end else begin
            qlen_nxt  = cmd_qlen;
            tlen_nxt  = cmd_tlen;
            cnt_nxt   = '0;
            state_nxt = LOAD_Q;
          end
        end
      end

      LOAD_Q: begin
        // Pads fill the far end of the chain so real bases land in the PEs nearest PE0's partners.
        if (cnt < npad) begin
          shifted        = 1'b1;
          pe_q_shift_nxt = 1'b1;
          pe_q_mask_nxt  = 1'b1;
        end else if (q_valid && q_ready) begin
          shifted        = 1'b1;
          pe_q_shift_nxt = 1'b1;
          pe_q_data_nxt  = q_data;
        end
        if (shifted) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == LEN_C) begin
            state_nxt    = CLEAR;
            cnt_nxt      = '0;
            pe_rst_n_nxt = 1'b0;
          end
        end
      end

      CLEAR: begin
        if (cnt == '0) begin
          pe_rst_n_nxt = 1'b0;
          cnt_nxt      = CNT_W'(1);
        end else begin
          state_nxt   = STREAM;
          tcnt_nxt    = '0;
          t_ready_nxt = 1'b1;
        end
      end

      STREAM: begin
        if (t_valid && t_ready) begin
          pe_en_nxt    = 1'b1;
          pe_data_nxt  = t_data;
          pe_first_nxt = (tcnt == '0);
          tcnt_nxt     = (tcnt == {TLEN_W{1'b1}}) ? tcnt : tcnt + TLEN_W'(1);
        end
        t_ready_nxt = (tcnt_nxt < tlen);
        if (tcnt_nxt >= tlen) begin
          state_nxt = DRAIN;
          tmo_nxt   = '0;
        end
      end

      DRAIN: begin
        tmo_nxt = tmo + TMO_W'(1);
        // A flag arriving on the timeout cycle still counts as a result.
        if (last_vld) begin
          state_nxt     = RESULT;
          res_valid_nxt = 1'b1;
          res_err_nxt   = 1'b0;
          score_load    = 1'b1;
        end else if (tmo == TMO_LAST) begin
          state_nxt     = RESULT;
          res_valid_nxt = 1'b1;
          res_err_nxt   = 1'b1;
          score_clear   = 1'b1;
        end
      end

      RESULT: begin
        if (res_valid && res_ready) begin
          state_nxt     = IDLE;
          res_valid_nxt = 1'b0;
          res_err_nxt   = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        cmd_ready_nxt = 1'b1;
        res_valid_nxt = 1'b0;
        res_err_nxt   = 1'b0;
      end
    endcase

    q_ready_nxt = (state_nxt == LOAD_Q) && (cnt_nxt >= (LEN_C - qlen_nxt)) && (cnt_nxt < LEN_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      qlen       <= '0;
      tlen       <= '0;
      tcnt       <= '0;
      tmo        <= '0;
      cmd_ready  <= 1'b1;
      q_ready    <= 1'b0;
      t_ready    <= 1'b0;
      pe_q_shift <= 1'b0;
      pe_q_data  <= _A;
      pe_q_mask  <= 1'b0;
      pe_rst_n   <= 1'b0;
      pe_en      <= 1'b0;
      pe_data    <= _A;
      pe_first   <= 1'b0;
      res_valid  <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      qlen       <= qlen_nxt;
      tlen       <= tlen_nxt;
      tcnt       <= tcnt_nxt;
      tmo        <= tmo_nxt;
      cmd_ready  <= cmd_ready_nxt;
      q_ready    <= q_ready_nxt;
      t_ready    <= t_ready_nxt;
      pe_q_shift <= pe_q_shift_nxt;
      pe_q_data  <= pe_q_data_nxt;
      pe_q_mask  <= pe_q_mask_nxt;
      pe_rst_n   <= pe_rst_n_nxt;
      pe_en      <= pe_en_nxt;
      pe_data    <= pe_data_nxt;
      pe_first   <= pe_first_nxt;
      res_valid  <= res_valid_nxt;
      res_err    <= res_err_nxt;
    end
  end

  // Score register updates on the same edge that enters RESULT.
  sw_score_unbias #(
    .SCORE_WIDTH(SCORE_WIDTH)
  ) u_unbias (
    .clk   (clk),
    .rst   (rst),
    .load  (score_load),
    .clear (score_clear),
    .high  (last_high),
    .score (res_score)
  );

endmodule
`default_nettype wire
